writeback_scoreboard: RTL and testbench
=======================================

// Module: writeback_scoreboard
// PURPOSE
//  Writeback stage directly upstream of the register bank: drives its write port (data_in/addr_in/write).
//  Merges ALU results (single-cycle, no backpressure) and memory results (multi-cycle, ready/valid).
//  Buffers memory results in a small FIFO and keeps a per-register busy scoreboard.
//  Decode uses the scoreboard to stall on RAW/WAW hazards.
// PARAMETERS
//  REGISTER_SIZE  32  data width of one register / result
//  ADDRESS_SIZE   5   register address width; 1<<ADDRESS_SIZE scoreboard bits
//  FIFO_DEPTH     4   memory-result buffer entries; power of two, >=2
// PORTS
//  clk          in   1              single clock; all state updates on posedge
//  reset        in   1              synchronous, active-high
//  alu_valid    in   1              ALU result present this cycle (must always be accepted)
//  alu_addr     in   ADDRESS_SIZE   ALU destination register
//  alu_data     in   REGISTER_SIZE  ALU result
//  mem_valid    in   1              memory result offered
//  mem_ready    out  1              FIFO can accept (= !fifo_full)
//  mem_addr     in   ADDRESS_SIZE   memory destination register
//  mem_data     in   REGISTER_SIZE  memory result
//  issue_valid  in   1              decode wants to issue an instruction this cycle
//  issue_src1   in   ADDRESS_SIZE   source operand 1
//  issue_src2   in   ADDRESS_SIZE   source operand 2
//  issue_dst    in   ADDRESS_SIZE   destination register
//  issue_has_dst in  1              instruction writes a register
//  stall        out  1              combinational: issue blocked by hazard
//  wb_write     out  1              registered: connect to register bank write
//  wb_addr      out  ADDRESS_SIZE   registered: connect to addr_in
//  wb_data      out  REGISTER_SIZE  registered: connect to data_in
// BEHAVIOUR
//  Reset: wb_write=0, wb_addr=0, wb_data=0, FIFO empty (mem_ready=1), all busy bits 0.
//  Reset mid-operation flushes the FIFO and the scoreboard; in-flight results are dropped.
//  Write select, evaluated each cycle, highest priority first:
//   1) alu_valid -> ALU result
//   2) FIFO non-empty -> FIFO head (pop)
//   3) mem_valid (FIFO empty) -> memory result, bypassing the FIFO
//   The selected result is registered onto wb_* at the next posedge.
//   wb_write stays high for exactly one cycle per result; the bank writes it in that cycle's low phase.
//  Latency: ALU result 1 cycle (accepted at edge N, visible on wb_* in cycle N+1).
//   Memory result: 1 cycle via bypass; otherwise queued.
//  Enqueue: mem_valid && mem_ready && !(case 3 bypass) -> push.
//   Push and pop in the same cycle are allowed, including when full: pop frees a slot, but mem_ready is based on pre-pop fullness.
//   mem_valid while !mem_ready: result ignored (protocol violation; bench asserts it never happens).
//  FIFO: circular buffer; read/write pointers are ADDRESS bits plus one wrap bit.
//   full/empty are derived from pointer equality and the wrap bit.
//  Scoreboard: busy[r] set at posedge when issue_valid && !stall && issue_has_dst, for r=issue_dst.
//   busy[r] is cleared at the posedge ending the cycle in which wb_write=1 and wb_addr=r.
//   Simultaneous set and clear of the same r: set wins (new pending producer).
//  stall = issue_valid && (busy[src1] || busy[src2] || (issue_has_dst && busy[dst])).
//   Register 0 is tracked like any other register (the bank has no hardwired zero).
//   WAW stall guarantees at most one pending producer per register, so no ordering hazard exists between the ALU and FIFO paths.
//  Same-cycle bypass of a write into stall is not provided.
//   A source cleared at edge N is unstalled in cycle N+1, when the bank already holds the value.
// STRUCTURE
//  Shared header writeback_defs.vh: FIFO_DEPTH default, WB_SEL_ALU/WB_SEL_FIFO/WB_SEL_MEM/WB_SEL_NONE encodings.
//  Sub-module result_fifo:
//   params WIDTH=ADDRESS_SIZE+REGISTER_SIZE, DEPTH
//   ports clk, reset, push, pop, din, dout, full, empty
//  Top holds the select mux, wb_* registers, busy vector and stall logic.
// TESTING
//  Reset for 2 cycles while alu_valid=1 -> wb_write=0, mem_ready=1, stall=0 throughout and after.
//  ALU alu_addr=3, alu_data=0xDEADBEEF at edge N -> cycle N+1: wb_write=1, wb_addr=3, wb_data=0xDEADBEEF.
//   In cycle N+2: wb_write=0.
//  ALU valid for 6 consecutive cycles with mem_valid=1 (addrs 8..):
//   FIFO fills; mem_ready=0 after 4 pushes.
//   After the ALU stops, 4 FIFO writes drain in order, then the bypass resumes.
//  Issue dst=5 (no stall), then issue src1=5 -> stall=1.
//   When the result for 5 appears on wb_* in cycle M, stall stays 1 in cycle M and drops to 0 in cycle M+1.
//  Issue dst=7 in the cycle wb_write=1 for addr 7 -> busy[7] remains 1 (set wins).
//   A later src=7 issue stalls.
//  Assert reset with 3 FIFO entries and 2 busy bits set -> next cycle empty, busy=0.
//   Queued entries never reach wb_*.

Source files
------------

// File: rtl/writeback_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_scoreboard_pkg
// Description : Shared types and constants for the writeback/scoreboard block.
//               Holds the default memory-result FIFO depth and the
//               writeback source-select encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package writeback_scoreboard_pkg;

  // Default number of buffered memory results (power of two, >= 2)
  localparam int WB_FIFO_DEPTH_DEFAULT = 4;

  // Which producer drives the register-bank write port next cycle
  typedef enum logic [1:0] {
    WB_SEL_NONE = 2'd0,
    WB_SEL_ALU  = 2'd1,
    WB_SEL_FIFO = 2'd2,
    WB_SEL_MEM  = 2'd3
  } wb_sel_e;

endpackage : writeback_scoreboard_pkg
`default_nettype wire

// File: rtl/result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : result_fifo
// Description : Circular-buffer FIFO for queued memory results. Pointers carry
//               one extra wrap bit so full and empty are told apart purely by
//               pointer comparison. The head entry is presented on dout.
// Revision    : 1.0 - initial release
// ============================================================================
module result_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  // Same slot index: equal wrap bits mean empty, differing wrap bits mean full
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &&
                 (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
  assign dout  = storage[rd_ptr[PTR_W-1:0]];

  // Pointer update; reset discards everything queued
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage; contents are don't-care until the write pointer passes them
  always_ff @(posedge clk) begin
    if (push) storage[wr_ptr[PTR_W-1:0]] <= din;
  end

endmodule : result_fifo
`default_nettype wire

// File: rtl/writeback_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : writeback_scoreboard
// Description : Writeback stage feeding the register bank write port. Merges
//               single-cycle ALU results with ready/valid memory results
//               (buffered in result_fifo) and keeps a per-register busy
//               scoreboard that decode uses to stall on RAW/WAW hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_scoreboard
  import writeback_scoreboard_pkg::*;
#(
  parameter int REGISTER_SIZE = 32,
  parameter int ADDRESS_SIZE  = 5,
  parameter int FIFO_DEPTH    = WB_FIFO_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [ADDRESS_SIZE-1:0]  alu_addr,
  input  logic [REGISTER_SIZE-1:0] alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDRESS_SIZE-1:0]  mem_addr,
  input  logic [REGISTER_SIZE-1:0] mem_data,
  input  logic                     issue_valid,
  input  logic [ADDRESS_SIZE-1:0]  issue_src1,
  input  logic [ADDRESS_SIZE-1:0]  issue_src2,
  input  logic [ADDRESS_SIZE-1:0]  issue_dst,
  input  logic                     issue_has_dst,
  output logic                     stall,
  output logic                     wb_write,
  output logic [ADDRESS_SIZE-1:0]  wb_addr,
  output logic [REGISTER_SIZE-1:0] wb_data
);

  localparam int NUM_REGS = 1 << ADDRESS_SIZE;
  localparam int ENTRY_W  = ADDRESS_SIZE + REGISTER_SIZE;

  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [ENTRY_W-1:0]       fifo_din;
  logic [ENTRY_W-1:0]       fifo_dout;

  wb_sel_e                  sel;
  logic [ADDRESS_SIZE-1:0]  sel_addr;
  logic [REGISTER_SIZE-1:0] sel_data;

  logic [NUM_REGS-1:0]      busy;
  logic [NUM_REGS-1:0]      busy_next;
  logic                     issue_accept;

  result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Ready reflects fullness before any same-cycle pop
  assign mem_ready = !fifo_full;
  assign fifo_din  = {mem_addr, mem_data};
  assign fifo_pop  = (sel == WB_SEL_FIFO);
  // A memory result that is not bypassed straight to the bank gets queued
  assign fifo_push = mem_valid && !fifo_full && (sel != WB_SEL_MEM);

  // Priority select: ALU, then oldest queued result, then direct memory bypass
  always_comb begin
    sel      = WB_SEL_NONE;
    sel_addr = mem_addr;
    sel_data = mem_data;
    if (alu_valid) begin
      sel      = WB_SEL_ALU;
      sel_addr = alu_addr;
      sel_data = alu_data;
    end else if (!fifo_empty) begin
      sel                  = WB_SEL_FIFO;
      {sel_addr, sel_data} = fifo_dout;
    end else if (mem_valid) begin
      sel = WB_SEL_MEM;
    end
  end

  // Write-port register: one-cycle write pulse; address/data hold when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_write <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      wb_write <= (sel != WB_SEL_NONE);
      if (sel != WB_SEL_NONE) begin
        wb_addr <= sel_addr;
        wb_data <= sel_data;
      end
    end
  end

  assign stall = issue_valid &&
                 (busy[issue_src1] || busy[issue_src2] ||
                  (issue_has_dst && busy[issue_dst]));
  assign issue_accept = issue_valid && !stall && issue_has_dst;

  // Scoreboard next state: retire the write in flight, then mark the new
  // producer so that a same-register set overrides the clear
  always_comb begin
    busy_next = busy;
    if (wb_write)     busy_next[wb_addr]   = 1'b0;
    if (issue_accept) busy_next[issue_dst] = 1'b1;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

endmodule : writeback_scoreboard
`default_nettype wire

// File: tb/tb_writeback_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_scoreboard
// Description : Self-checking bench for writeback_scoreboard: a directed
//               vector table, hand-written multi-cycle sequences and a
//               randomized run, all compared against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_scoreboard;

  localparam int DEPTH = 4;

  typedef struct {
    bit          rst;
    bit          av;
    logic [4:0]  aa;
    logic [31:0] ad;
    bit          mv;
    logic [4:0]  ma;
    logic [31:0] md;
    bit          iv;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  dst;
    bit          hd;
  } stim_t;

  typedef struct {
    stim_t       s;
    bit          ready;
    bit          stl;
    bit          wr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, alu_valid, mem_valid, mem_ready, issue_valid, issue_has_dst;
  logic        stall, wb_write;
  logic [4:0]  alu_addr, mem_addr, issue_src1, issue_src2, issue_dst, wb_addr;
  logic [31:0] alu_data, mem_data, wb_data;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [36:0] m_q[$];
  bit          m_busy [32];
  bit          m_wr;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          model_ok = 1'b0;

  logic obs_ready, obs_stall;

  writeback_scoreboard dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_src1(issue_src1), .issue_src2(issue_src2),
    .issue_dst(issue_dst), .issue_has_dst(issue_has_dst),
    .stall(stall), .wb_write(wb_write), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic stim_t mk(bit rst, bit av, logic [4:0] aa, logic [31:0] ad,
                               bit mv, logic [4:0] ma, logic [31:0] md,
                               bit iv, logic [4:0] s1, logic [4:0] s2,
                               logic [4:0] dst, bit hd);
    stim_t s;
    s.rst = rst; s.av = av; s.aa = aa; s.ad = ad;
    s.mv = mv; s.ma = ma; s.md = md;
    s.iv = iv; s.s1 = s1; s.s2 = s2; s.dst = dst; s.hd = hd;
    return s;
  endfunction

  function automatic vec_t mkv(stim_t s, bit r, bit st, bit wr, logic [4:0] a, logic [31:0] d);
    vec_t v;
    v.s = s; v.ready = r; v.stl = st; v.wr = wr; v.waddr = a; v.wdata = d;
    return v;
  endfunction

  // Model: one clock of the writeback/scoreboard rules
  task automatic model_step(input stim_t s);
    bit ready, was_empty, stl;
    if (s.rst) begin
      m_q.delete();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_wr = 1'b0; m_addr = '0; m_data = '0;
      return;
    end
    ready     = (m_q.size() < DEPTH);
    was_empty = (m_q.size() == 0);
    stl = s.iv && (m_busy[s.s1] || m_busy[s.s2] || (s.hd && m_busy[s.dst]));
    if (m_wr) m_busy[m_addr] = 1'b0;
    if (s.iv && !stl && s.hd) m_busy[s.dst] = 1'b1;
    if (s.av) begin
      m_wr = 1'b1; m_addr = s.aa; m_data = s.ad;
    end else if (!was_empty) begin
      m_wr = 1'b1; {m_addr, m_data} = m_q.pop_front();
    end else if (s.mv) begin
      m_wr = 1'b1; m_addr = s.ma; m_data = s.md;
    end else begin
      m_wr = 1'b0;
    end
    if (s.mv && ready && (s.av || !was_empty)) m_q.push_back({s.ma, s.md});
  endtask

  // Apply one cycle of stimulus, compare combinational and registered outputs to the model
  task automatic apply(input stim_t s);
    bit exp_ready, exp_stall;
    reset = s.rst; alu_valid = s.av; alu_addr = s.aa; alu_data = s.ad;
    mem_valid = s.mv; mem_addr = s.ma; mem_data = s.md;
    issue_valid = s.iv; issue_src1 = s.s1; issue_src2 = s.s2;
    issue_dst = s.dst; issue_has_dst = s.hd;
    #2;
    obs_ready = mem_ready;
    obs_stall = stall;
    if (model_ok) begin
      exp_ready = (m_q.size() < DEPTH);
      exp_stall = s.iv && (m_busy[s.s1] || m_busy[s.s2] || (s.hd && m_busy[s.dst]));
      chk("mem_ready", {31'd0, mem_ready}, {31'd0, exp_ready});
      chk("stall", {31'd0, stall}, {31'd0, exp_stall});
      if (s.mv && !s.rst) chk("mem_protocol", {31'd0, mem_ready}, 32'd1);
    end
    model_step(s);
    @(posedge clk);
    #1;
    chk("wb_write", {31'd0, wb_write}, {31'd0, m_wr});
    if (m_wr || s.rst) begin
      chk("wb_addr", {27'd0, wb_addr}, {27'd0, m_addr});
      chk("wb_data", wb_data, m_data);
    end
  endtask

  vec_t  tbl [14];
  stim_t idle;
  stim_t s;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //            rst av aa  ad            mv ma  md     iv s1 s2 dst hd
    tbl[0]  = mkv(mk(1, 1, 3, 32'h1111,    0, 0,  0,     0, 0, 0, 0, 0), 1, 0, 0, 0,  0);
    tbl[1]  = mkv(mk(1, 1, 3, 32'h1111,    0, 0,  0,     0, 0, 0, 0, 0), 1, 0, 0, 0,  0);
    tbl[2]  = mkv(mk(0, 0, 0, 0,           0, 0,  0,     0, 0, 0, 0, 0), 1, 0, 0, 0,  0);
    tbl[3]  = mkv(mk(0, 1, 3, 32'hDEADBEEF,0, 0,  0,     0, 0, 0, 0, 0), 1, 0, 1, 3,  32'hDEADBEEF);
    tbl[4]  = mkv(mk(0, 0, 0, 0,           0, 0,  0,     0, 0, 0, 0, 0), 1, 0, 0, 0,  0);
    tbl[5]  = mkv(mk(0, 0, 0, 0,           0, 0,  0,     1, 0, 0, 5, 1), 1, 0, 0, 0,  0);
    tbl[6]  = mkv(mk(0, 0, 0, 0,           0, 0,  0,     1, 5, 0, 0, 0), 1, 1, 0, 0,  0);
    tbl[7]  = mkv(mk(0, 1, 5, 32'h55,      0, 0,  0,     1, 5, 0, 0, 0), 1, 1, 1, 5,  32'h55);
    tbl[8]  = mkv(mk(0, 0, 0, 0,           0, 0,  0,     1, 5, 0, 0, 0), 1, 1, 0, 0,  0);
    tbl[9]  = mkv(mk(0, 0, 0, 0,           0, 0,  0,     1, 5, 0, 0, 0), 1, 0, 0, 0,  0);
    tbl[10] = mkv(mk(0, 0, 0, 0,           1, 9,  32'h99,0, 0, 0, 0, 0), 1, 0, 1, 9,  32'h99);
    tbl[11] = mkv(mk(0, 1, 10,32'hA,       1, 11, 32'hB, 0, 0, 0, 0, 0), 1, 0, 1, 10, 32'hA);
    tbl[12] = mkv(mk(0, 0, 0, 0,           0, 0,  0,     0, 0, 0, 0, 0), 1, 0, 1, 11, 32'hB);
    tbl[13] = mkv(mk(0, 0, 0, 0,           0, 0,  0,     0, 0, 0, 0, 0), 1, 0, 0, 0,  0);

    // Unchecked power-on cycle: state is unknown until the first reset edge
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    model_ok = 1'b1;

    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].s);
      chk($sformatf("tbl%0d_ready", i), {31'd0, obs_ready}, {31'd0, tbl[i].ready});
      chk($sformatf("tbl%0d_stall", i), {31'd0, obs_stall}, {31'd0, tbl[i].stl});
      chk($sformatf("tbl%0d_write", i), {31'd0, wb_write}, {31'd0, tbl[i].wr});
      if (tbl[i].wr || tbl[i].s.rst) begin
        chk($sformatf("tbl%0d_addr", i), {27'd0, wb_addr}, {27'd0, tbl[i].waddr});
        chk($sformatf("tbl%0d_data", i), wb_data, tbl[i].wdata);
      end
    end

    // FIFO fill: ALU busy for 6 cycles while memory offers results 8, 9, ...
    begin
      int pushed = 0;
      for (int i = 0; i < 6; i++) begin
        s = idle;
        s.av = 1; s.aa = 5'(20 + i); s.ad = 32'(i);
        s.mv = (m_q.size() < DEPTH);
        s.ma = 5'(8 + pushed); s.md = 32'(100 + pushed);
        if (s.mv) pushed++;
        apply(s);
        if (i == 4) chk("fill_ready_low", {31'd0, obs_ready}, 32'd0);
      end
      for (int k = 0; k < 4; k++) begin
        apply(idle);
        if (k == 0) chk("drain_ready_prepop", {31'd0, obs_ready}, 32'd0);
        chk($sformatf("drain%0d_write", k), {31'd0, wb_write}, 32'd1);
        chk($sformatf("drain%0d_addr", k), {27'd0, wb_addr}, 32'(8 + k));
        chk($sformatf("drain%0d_data", k), wb_data, 32'(100 + k));
      end
      s = idle; s.mv = 1; s.ma = 12; s.md = 32'hC0DE;
      apply(s);
      chk("bypass_after_drain_addr", {27'd0, wb_addr}, 32'd12);
      chk("bypass_after_drain_data", wb_data, 32'hC0DE);
    end

    // Set wins over clear: claim r7 in the cycle its write is on wb_*
    s = idle; s.av = 1; s.aa = 7; s.ad = 32'h77;
    apply(s);
    s = idle; s.iv = 1; s.dst = 7; s.hd = 1;
    apply(s);
    chk("setwins_issue_stall", {31'd0, obs_stall}, 32'd0);
    apply(idle);
    s = idle; s.iv = 1; s.s1 = 7;
    apply(s);
    chk("setwins_later_stall", {31'd0, obs_stall}, 32'd1);

    // Reset flush: three queued results and two busy registers
    for (int i = 0; i < 3; i++) begin
      s = idle;
      s.av = 1; s.aa = 5'(24 + i); s.ad = 32'(i);
      s.mv = 1; s.ma = 5'(16 + i); s.md = 32'hF00 + 32'(i);
      if (i < 2) begin s.iv = 1; s.dst = 5'(1 + i); s.hd = 1; end
      apply(s);
    end
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    s = idle; s.iv = 1; s.s1 = 1; s.s2 = 2;
    apply(s);
    chk("flush_ready", {31'd0, obs_ready}, 32'd1);
    chk("flush_stall", {31'd0, obs_stall}, 32'd0);
    chk("flush_no_write0", {31'd0, wb_write}, 32'd0);
    for (int k = 1; k < 4; k++) begin
      apply(idle);
      chk($sformatf("flush_no_write%0d", k), {31'd0, wb_write}, 32'd0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      s.rst = ($urandom_range(0, 199) == 0);
      s.av  = ($urandom_range(0, 2) == 0);
      s.aa  = 5'($urandom_range(0, 7));
      s.ad  = $urandom;
      s.mv  = (m_q.size() < DEPTH) && ($urandom_range(0, 1) == 1);
      s.ma  = 5'($urandom_range(0, 7));
      s.md  = $urandom;
      s.iv  = ($urandom_range(0, 1) == 1);
      s.s1  = 5'($urandom_range(0, 7));
      s.s2  = 5'($urandom_range(0, 7));
      s.dst = 5'($urandom_range(0, 7));
      s.hd  = ($urandom_range(0, 3) != 0);
      apply(s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_writeback_scoreboard
`default_nettype wire
